// File: rtl/fp_mant_mult.sv
// Multi-cycle significand multiplier: unpacks two packed floats, forms the full
// product with a radix-2 shift-add loop, and hands {mant, shift, exp_sum, sign} downstream.
module fp_mant_mult #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  localparam int SHIFT_W = $clog2(2*MANT_W+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W-1:0] a,
  input  logic [EXP_W+MANT_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*MANT_W-1:0]     mant,
  output logic [SHIFT_W-1:0]      shift,
  output logic signed [EXP_W:0]   exp_sum,
  output logic                    sign,
  output logic                    out_nan,
  output logic                    out_inf,
  output logic [1:0]              fsm_state
);

  localparam int W     = EXP_W + MANT_W;
  localparam int P     = 2 * MANT_W;
  localparam int CNT_W = $clog2(MANT_W);
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and the result
  // fields hold steady while out_valid is high and out_ready is low.
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  logic [P-1:0]       acc;
  logic [P-1:0]       acc_next;
  logic [P-1:0]       addend;
  logic [MANT_W-1:0]  mcand;
  logic [MANT_W-1:0]  mplier;
  logic [CNT_W-1:0]   cnt;

  logic [EXP_W-1:0]   ea_f, eb_f;
  logic [MANT_W-2:0]  fa, fb;
  logic [MANT_W-1:0]  sig_a, sig_b;
  logic signed [EXP_W+1:0] eff_a, eff_b, sum_raw;
  logic [EXP_W:0]     sum_sat;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic               nan_in, inf_in;

  assign ea_f  = a[W-2 -: EXP_W];
  assign eb_f  = b[W-2 -: EXP_W];
  assign fa    = a[MANT_W-2:0];
  assign fb    = b[MANT_W-2:0];
  // Subnormals have no hidden bit and behave as if their exponent were 1.
  assign sig_a = {(ea_f != '0), fa};
  assign sig_b = {(eb_f != '0), fb};
  assign eff_a = (ea_f == '0) ? (EXP_W+2)'(1) : {2'b00, ea_f};
  assign eff_b = (eb_f == '0) ? (EXP_W+2)'(1) : {2'b00, eb_f};
  assign sum_raw = eff_a + eff_b - BIAS;
  assign sum_sat = (sum_raw > EMAX) ? EMAX[EXP_W:0] : sum_raw[EXP_W:0];

  assign a_nan  = (&ea_f) && (|fa);
  assign b_nan  = (&eb_f) && (|fb);
  assign a_inf  = (&ea_f) && !(|fa);
  assign b_inf  = (&eb_f) && !(|fb);
  assign a_zero = (ea_f == '0) && (fa == '0);
  assign b_zero = (eb_f == '0) && (fb == '0);
  assign nan_in = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  assign inf_in = (a_inf || b_inf) && !nan_in;

  assign addend   = mplier[cnt] ? ({{MANT_W{1'b0}}, mcand} << cnt) : '0;
  assign acc_next = acc + addend;

  function automatic logic [SHIFT_W-1:0] lzc(input logic [P-1:0] v);
    lzc = SHIFT_W'(P);
    for (int i = 0; i < P; i++) begin
      if (v[i]) lzc = SHIFT_W'(P - 1 - i);
    end
  endfunction

  assign in_ready  = (state == IDLE);
  assign mant      = acc;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      shift     <= '0;
      exp_sum   <= '0;
      sign      <= 1'b0;
      out_nan   <= 1'b0;
      out_inf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand   <= sig_a;
            mplier  <= sig_b;
            acc     <= '0;
            cnt     <= '0;
            exp_sum <= sum_sat;
            sign    <= a[W-1] ^ b[W-1];
            out_nan <= nan_in;
            out_inf <= inf_in;
            state   <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MANT_W-1)) begin
            // Count on the final sum so shift is ready together with out_valid.
            shift     <= lzc(acc_next);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mant_mult.sv
// Bench for fp_mant_mult: vector table plus random normals through a scoreboard,
// then backpressure and mid-operation reset sequences.
module tb_fp_mant_mult;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int W      = 32;
  localparam int P      = 48;
  localparam int SW     = 6;
  localparam int EW     = 67;
  localparam int NV     = 11;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, sign, out_nan, out_inf;
  logic [W-1:0] a, b;
  logic [P-1:0] mant;
  logic [SW-1:0] shift;
  logic signed [EXP_W:0] exp_sum;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  fp_mant_mult #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .mant(mant), .shift(shift), .exp_sum(exp_sum), .sign(sign),
    .out_nan(out_nan), .out_inf(out_inf), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        care;
    logic [47:0] mant;
    logic [5:0]  shift;
    int          e;
    logic        s;
    logic        nan;
    logic        inf;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input vec_t v);
    logic [8:0] e9;
    e9 = 9'(v.e);
    return {v.care, v.mant, v.shift, e9, v.s, v.nan, v.inf};
  endfunction

  // Reference for normal operands: integer multiply and top-down zero count.
  function automatic logic [EW-1:0] model(input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    logic [23:0] sx, sy;
    int ex, ey;
    sx = {(x[30:23] != 8'd0), x[22:0]};
    sy = {(y[30:23] != 8'd0), y[22:0]};
    ex = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
    v.a = x; v.b = y; v.care = 1'b1;
    v.mant = 48'(sx) * 48'(sy);
    v.shift = 6'd48;
    for (int i = 47; i >= 0; i--) begin
      if (v.mant[i]) begin
        v.shift = 6'(47 - i);
        break;
      end
    end
    v.e = ex + ey - 127;
    if (v.e > 255) v.e = 255;
    v.s = x[31] ^ y[31];
    v.nan = 1'b0;
    v.inf = 1'b0;
    return pack_exp(v);
  endfunction

  task automatic send(input logic [31:0] xa, input logic [31:0] xb);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_at_send", 64'(in_ready), 64'd1);
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 64'(n), 64'd24);
  endtask

  task automatic compare_top();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=result required=none");
    end else begin
      e = exp_q.pop_front();
      if (e[66]) begin
        check("mant", 64'(mant), 64'(e[65:18]));
        check("shift", 64'(shift), 64'(e[17:12]));
      end
      check("exp_sum", {55'd0, exp_sum}, 64'(e[11:3]));
      check("sign", 64'(sign), 64'(e[2]));
      check("out_nan", 64'(out_nan), 64'(e[1]));
      check("out_inf", 64'(out_inf), 64'(e[0]));
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handoff", 64'(out_valid), 64'd0);
    check("in_ready_after_handoff", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [EW-1:0] e);
    exp_q.push_back(e);
    send(xa, xb);
    wait_valid();
    compare_top();
    handoff();
  endtask

  initial begin
    logic [47:0] held_mant;
    logic [31:0] ra, rb;
    logic        phantom;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, 48'h400000000000, 6'd1,  127, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 48'h900000000000, 6'd0,  127, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h40000000, 32'hC0400000, 1'b1, 48'h600000000000, 6'd1,  129, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h00000000, 32'h40A00000, 1'b1, 48'h000000000000, 6'd48, 3,   1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 1'b0, 48'h0,           6'd0,  129, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h7F000000, 32'h7F000000, 1'b1, 48'h400000000000, 6'd1,  255, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h00000001, 32'h3F800000, 1'b1, 48'h000000800000, 6'd24, 1,   1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 48'h0,           6'd0,  255, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 48'h0,           6'd0,  255, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1, 48'hFFFFFE000001, 6'd0,  127, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 48'h000000000000, 6'd48, -125, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_mant", 64'(mant), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, pack_exp(vecs[i]));
    end

    for (int i = 0; i < 8; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      run_op(ra, rb, model(ra, rb));
    end

    // Backpressure: result must hold and ignore operand pulses until released.
    exp_q.push_back(pack_exp(vecs[0]));
    send(32'h3F800000, 32'h3F800000);
    wait_valid();
    held_mant = mant;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_mant_hold", 64'(mant), 64'(held_mant));
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    compare_top();
    a = 32'h40000000; b = 32'h40000000; in_valid = 1'b1;
    handoff();
    in_valid = 1'b0;
    phantom = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) phantom = 1'b1;
    end
    check("no_accept_on_handoff", 64'(phantom), 64'd0);

    // Reset in the middle of the multiply loop discards the operation.
    send(32'h3FC00000, 32'hC0400000);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_mant", 64'(mant), 64'd0);
    check("mid_rst_shift", 64'(shift), 64'd0);
    check("mid_rst_exp_sum", {55'd0, exp_sum}, 64'd0);
    check("mid_rst_flags", 64'({sign, out_nan, out_inf}), 64'd0);
    check("mid_rst_state", 64'(fsm_state), 64'd0);
    run_op(vecs[0].a, vecs[0].b, pack_exp(vecs[0]));

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
